// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the FP ALU scheduler.
// Op codes, FSM states and the default word width.
package fp_alu_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

endpackage

// File: rtl/fp_alu_sched_rr_arb.sv
// Combinational round-robin arbiter.
// Searches from ptr+1 upward, wrapping, and returns a one-hot grant.
module rr_arb #(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   gnt_id,
   output logic            any
);

   // first requester after the pointer wins
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NREQ]) begin
            any = 1'b1;
            gnt[(int'(ptr) + k) % NREQ] = 1'b1;
            gnt_id = PW'((int'(ptr) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/fp_alu_sched.sv
// Round-robin scheduler in front of one shared multicycle FP ALU.
// Operands are held for LAT cycles, then the result is handed back.
module fp_alu_sched
   import fp_alu_pkg::*;
#(
   parameter int M    = 8,
   parameter int N    = 23,
   parameter int NREQ = 2,
   parameter int LAT  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*(M+N+1)-1:0]   req_a,
   input  logic [NREQ*(M+N+1)-1:0]   req_b,
   input  logic [NREQ*2-1:0]         req_op,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [M+N:0]              rsp_c,
   output logic [M+N:0]              alu_a,
   output logic [M+N:0]              alu_b,
   output logic [1:0]                alu_op,
   input  logic [M+N:0]              alu_c,
   output logic                      busy
);

   localparam int W  = M + N + 1;
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(LAT + 1);

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   owner;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [1:0]      op_q;
   logic [W-1:0]    res;

   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_id;
   logic            gnt_any;

   rr_arb #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (gnt_any)
   );

   assign req_ready = (state == IDLE) ? gnt : '0;
   assign rsp_c     = res;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign busy      = (state != IDLE);

   // response strobe goes only to the owner of the op
   always_comb begin
      rsp_valid = '0;
      if (state == RESP)
         rsp_valid[owner] = 1'b1;
   end

   // accept, hold operands for LAT cycles, then return result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= PW'(NREQ - 1);
         owner <= '0;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         res   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt_any) begin
                  a_q   <= req_a[int'(gnt_id)*W +: W];
                  b_q   <= req_b[int'(gnt_id)*W +: W];
                  op_q  <= req_op[int'(gnt_id)*2 +: 2];
                  owner <= gnt_id;
                  ptr   <= gnt_id;
                  cnt   <= CW'(LAT - 1);
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  res   <= alu_c;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[owner])
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_alu_sched.sv
// Directed bench for fp_alu_sched.
// Three instances cover NREQ=2/LAT=4, NREQ=4/LAT=4 and NREQ=2/LAT=3.
module tb_fp_alu_sched;

   localparam int W = 32;
   localparam int LA = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc_cnt = 0;

   // free-running count, used as a changing ALU result
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] op);
      if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000)
         return 32'h40400000;
      if (op == 2'b01 && a == 32'h40A00000 && b == 32'h40400000)
         return 32'h40000000;
      if (op == 2'b10 && a == 32'h3FC00000 && b == 32'h40000000)
         return 32'h40400000;
      if (op == 2'b11 && a == 32'h40C00000 && b == 32'h40000000)
         return 32'h40400000;
      return a ^ b ^ {30'd0, op};
   endfunction

   // instance A: NREQ=2, LAT=4
   logic [1:0]     a_rv, a_rr, a_sv, a_sr, a_aluop;
   logic [2*W-1:0] a_ra, a_rb;
   logic [3:0]     a_rop;
   logic [W-1:0]   a_c, a_alua, a_alub, a_aluc;
   logic           a_busy;
   assign a_aluc = alu_fn(a_alua, a_alub, a_aluop);

   fp_alu_sched #(.M(8), .N(23), .NREQ(2), .LAT(LA)) u_a (
      .clk(clk), .rst(rst),
      .req_valid(a_rv), .req_ready(a_rr),
      .req_a(a_ra), .req_b(a_rb), .req_op(a_rop),
      .rsp_valid(a_sv), .rsp_ready(a_sr), .rsp_c(a_c),
      .alu_a(a_alua), .alu_b(a_alub), .alu_op(a_aluop),
      .alu_c(a_aluc), .busy(a_busy)
   );

   // instance B: NREQ=4, LAT=4
   logic [3:0]     b_rv, b_rr, b_sv, b_sr;
   logic [1:0]     b_aluop;
   logic [4*W-1:0] b_ra, b_rb;
   logic [7:0]     b_rop;
   logic [W-1:0]   b_c, b_alua, b_alub, b_aluc;
   logic           b_busy;
   assign b_aluc = alu_fn(b_alua, b_alub, b_aluop);

   fp_alu_sched #(.M(8), .N(23), .NREQ(4), .LAT(LA)) u_b (
      .clk(clk), .rst(rst),
      .req_valid(b_rv), .req_ready(b_rr),
      .req_a(b_ra), .req_b(b_rb), .req_op(b_rop),
      .rsp_valid(b_sv), .rsp_ready(b_sr), .rsp_c(b_c),
      .alu_a(b_alua), .alu_b(b_alub), .alu_op(b_aluop),
      .alu_c(b_aluc), .busy(b_busy)
   );

   // instance C: NREQ=2, LAT=3, result is the cycle count
   logic [1:0]     c_rv, c_rr, c_sv, c_sr, c_aluop;
   logic [2*W-1:0] c_ra, c_rb;
   logic [3:0]     c_rop;
   logic [W-1:0]   c_c, c_alua, c_alub, c_aluc;
   logic           c_busy;
   assign c_aluc = cyc_cnt;

   fp_alu_sched #(.M(8), .N(23), .NREQ(2), .LAT(3)) u_c (
      .clk(clk), .rst(rst),
      .req_valid(c_rv), .req_ready(c_rr),
      .req_a(c_ra), .req_b(c_rb), .req_op(c_rop),
      .rsp_valid(c_sv), .rsp_ready(c_sr), .rsp_c(c_c),
      .alu_a(c_alua), .alu_b(c_alub), .alu_op(c_aluop),
      .alu_c(c_aluc), .busy(c_busy)
   );

   typedef struct {
      int         r;
      logic [1:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } vec_t;

   vec_t v[6];
   logic [3:0]  gq[$];
   logic [3:0]  sq[$];
   logic [31:0] cq[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic txn_a(input int idx, input vec_t t);
      int lat;
      bit got;
      @(posedge clk); #1;
      a_rv = '0;
      a_rv[t.r] = 1'b1;
      a_ra[t.r*W +: W] = t.a;
      a_rb[t.r*W +: W] = t.b;
      a_rop[t.r*2 +: 2] = t.op;
      a_sr = 2'b11;
      @(negedge clk);
      chk($sformatf("v%0d req_ready", idx), 64'(a_rr), 64'(2'b01 << t.r));
      lat = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         a_rv = '0;
         a_ra = '1;
         a_rb = '1;
         a_rop = '1;
         @(negedge clk);
         lat++;
         if (a_sv != 0) got = 1;
      end
      chk($sformatf("v%0d latency", idx), 64'(lat), 64'(LA + 1));
      chk($sformatf("v%0d rsp_valid", idx), 64'(a_sv), 64'(2'b01 << t.r));
      chk($sformatf("v%0d rsp_c", idx), 64'(a_c), 64'(t.c));
   endtask

   task automatic drain_a();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!a_busy) break;
      end
   endtask

   initial begin
      int bad_v, bad_c, bad_r, bad02, bad_alu;
      logic [31:0] held, samp;

      v[0] = '{0, 2'b11, 32'h40C00000, 32'h40000000, 32'h40400000};
      v[1] = '{1, 2'b00, 32'h3F800000, 32'h40000000, 32'h40400000};
      v[2] = '{0, 2'b01, 32'h40A00000, 32'h40400000, 32'h40000000};
      v[3] = '{1, 2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000};
      v[4] = '{0, 2'b00, 32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977};
      v[5] = '{1, 2'b11, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFC};

      rst = 1'b1;
      a_rv = '0; a_sr = '0; a_ra = '0; a_rb = '0; a_rop = '0;
      b_rv = '0; b_sr = '0; b_ra = '0; b_rb = '0; b_rop = '0;
      c_rv = '0; c_sr = '0; c_ra = '0; c_rb = '0; c_rop = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst busy", 64'(a_busy), 64'd0);
      chk("rst rsp_valid", 64'(a_sv), 64'd0);
      chk("rst rsp_c", 64'(a_c), 64'd0);
      chk("rst alu_a", 64'(a_alua), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle req_ready", 64'(a_rr), 64'd0);
      chk("idle busy", 64'(a_busy), 64'd0);

      // single transactions from the table
      for (int i = 0; i < 6; i++)
         txn_a(i, v[i]);

      // both requesters valid continuously
      @(posedge clk); #1;
      a_rv = 2'b11;
      a_sr = 2'b11;
      a_ra = {v[1].a, v[0].a};
      a_rb = {v[1].b, v[0].b};
      a_rop = {v[1].op, v[0].op};
      gq.delete();
      sq.delete();
      for (int k = 0; k < 60 && sq.size() < 4; k++) begin
         @(negedge clk);
         if (a_rr != 0) gq.push_back(4'(a_rr));
         if (a_sv != 0) sq.push_back(4'(a_sv));
      end
      @(posedge clk); #1;
      a_rv = '0;
      chk("rot grants", 64'(gq.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rot grant%0d", i),
             64'(gq.size() > i ? gq[i] : 4'd0),
             64'((i % 2 == 0) ? 4'b0001 : 4'b0010));
         chk($sformatf("rot rsp%0d", i),
             64'(sq.size() > i ? sq[i] : 4'd0),
             64'((i % 2 == 0) ? 4'b0001 : 4'b0010));
      end
      drain_a();

      // response stall with rsp_ready low
      @(posedge clk); #1;
      a_rv = 2'b01;
      a_sr = 2'b00;
      a_ra[0 +: W] = v[1].a;
      a_rb[0 +: W] = v[1].b;
      a_rop[1:0] = v[1].op;
      @(negedge clk);
      chk("stall grant0", 64'(a_rr), 64'd1);
      @(posedge clk); #1;
      a_rv = 2'b10;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (a_sv != 0) break;
      end
      held = a_c;
      chk("stall rsp_c", 64'(held), 64'h40400000);
      bad_v = 0; bad_c = 0; bad_r = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (a_sv !== 2'b01) bad_v++;
         if (a_c !== held) bad_c++;
         if (a_rr !== 2'b00) bad_r++;
      end
      chk("stall valid held", 64'(bad_v), 64'd0);
      chk("stall data held", 64'(bad_c), 64'd0);
      chk("stall no ready", 64'(bad_r), 64'd0);
      @(posedge clk); #1;
      a_sr = 2'b01;
      @(negedge clk);
      chk("stall release ready", 64'(a_rr), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall req1 grant", 64'(a_rr), 64'd2);
      @(posedge clk); #1;
      a_rv = '0;
      a_sr = 2'b11;
      drain_a();

      // reset in the second EXEC cycle
      @(posedge clk); #1;
      a_rv = 2'b01;
      a_ra[0 +: W] = v[0].a;
      a_rb[0 +: W] = v[0].b;
      a_rop[1:0] = v[0].op;
      @(negedge clk);
      chk("mid grant0", 64'(a_rr), 64'd1);
      @(posedge clk); #1;
      a_rv = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid busy", 64'(a_busy), 64'd0);
      chk("mid rsp_valid", 64'(a_sv), 64'd0);
      chk("mid alu_a", 64'(a_alua), 64'd0);
      chk("mid alu_b", 64'(a_alub), 64'd0);
      chk("mid alu_op", 64'(a_aluop), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      bad_v = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (a_sv != 0 || a_busy) bad_v++;
      end
      chk("mid no response", 64'(bad_v), 64'd0);
      @(posedge clk); #1;
      a_rv = 2'b11;
      @(negedge clk);
      chk("mid first grant", 64'(a_rr), 64'd1);
      @(posedge clk); #1;
      a_rv = '0;
      drain_a();

      // NREQ=4 with requesters 1 and 3 valid
      @(posedge clk); #1;
      b_rv = 4'b1010;
      b_sr = 4'b1111;
      b_ra[1*W +: W] = v[3].a;
      b_rb[1*W +: W] = v[3].b;
      b_rop[2 +: 2] = v[3].op;
      b_ra[3*W +: W] = v[2].a;
      b_rb[3*W +: W] = v[2].b;
      b_rop[6 +: 2] = v[2].op;
      gq.delete();
      cq.delete();
      bad02 = 0;
      for (int k = 0; k < 60 && gq.size() < 4; k++) begin
         @(negedge clk);
         if (b_rr != 0) gq.push_back(b_rr);
         if (b_rr[0] || b_rr[2]) bad02++;
         if (b_sv != 0) cq.push_back(b_c);
      end
      @(posedge clk); #1;
      b_rv = '0;
      chk("q4 grants", 64'(gq.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("q4 grant%0d", i),
             64'(gq.size() > i ? gq[i] : 4'd0),
             64'((i % 2 == 0) ? 4'b0010 : 4'b1000));
      chk("q4 no 0/2", 64'(bad02), 64'd0);
      chk("q4 rsp1 c", 64'(cq.size() > 0 ? cq[0] : 32'd0), 64'h40400000);
      chk("q4 rsp3 c", 64'(cq.size() > 1 ? cq[1] : 32'd0), 64'h40000000);
      repeat (10) @(posedge clk);

      // LAT=3, result captured from the last EXEC cycle
      @(posedge clk); #1;
      c_rv = 2'b01;
      c_sr = 2'b11;
      c_ra[0 +: W] = 32'hA5A5A5A5;
      c_rb[0 +: W] = 32'h5A5A5A5A;
      c_rop[1:0] = 2'b10;
      @(negedge clk);
      chk("l3 grant", 64'(c_rr), 64'd1);
      bad_alu = 0;
      samp = '0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         c_rv = '0;
         c_ra = '1;
         c_rb = '0;
         c_rop = '1;
         @(negedge clk);
         if (c_alua !== 32'hA5A5A5A5 || c_alub !== 32'h5A5A5A5A ||
             c_aluop !== 2'b10 || !c_busy)
            bad_alu++;
         if (k == 3) samp = cyc_cnt;
      end
      chk("l3 alu stable", 64'(bad_alu), 64'd0);
      @(negedge clk);
      chk("l3 rsp_valid", 64'(c_sv), 64'd1);
      chk("l3 rsp_c", 64'(c_c), 64'(samp));
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
